rr_prio_encoder: RTL and testbench

Registered N-input priority encoder and arbiter with a run-time choice of fixed-priority or round-robin selection. It is the parametrised successor of the team's 4-input combinational encoders. It samples a request vector and produces a held grant, both as a binary index and as a one-hot vector. The grant is released by an acknowledge handshake or by the requester withdrawing. It sits between request sources and a shared resource controller.

---
 rtl/arb_pkg.sv | 12 +
 rtl/prio_pick.sv | 51 +++++
 rtl/rr_prio_encoder.sv | 96 +++++++++
 tb/tb_rr_prio_encoder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the registered priority encoder / arbiter.
package arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational winner search: highest-index (fixed) or first-at-or-above-pointer
// with wrap (round-robin).
module prio_pick
  import arb_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  logic         m_found;
  logic [W-1:0] m_idx;
  logic [W-1:0] hi_idx;
  logic [W-1:0] lo_idx;

  always_comb begin
    m_found = 1'b0;
    m_idx   = '0;
    hi_idx  = '0;
    lo_idx  = '0;
    found   = |req;
    idx     = '0;
    onehot  = '0;

    // Ascending scan leaves the highest set index.
    for (int i = 0; i < int'(N); i++) begin
      if (req[i]) hi_idx = W'(i);
    end

    // Descending scan leaves the lowest set index overall and at/above ptr.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) lo_idx = W'(i);
      if (req[i] && (i >= int'(ptr))) begin
        m_found = 1'b1;
        m_idx   = W'(i);
      end
    end

    if (mode == MODE_FIXED) idx = hi_idx;
    else                    idx = m_found ? m_idx : lo_idx;

    if (found) onehot = N'(1) << idx;
  end

endmodule

// File: rtl/rr_prio_encoder.sv
// Registered N-input arbiter: fixed-priority or round-robin pick, grant held
// until acknowledged or withdrawn.
module rr_prio_encoder
  import arb_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] rr_ptr
);

  state_e       state_q, state_d;
  logic         valid_d;
  logic [W-1:0] idx_d;
  logic [N-1:0] onehot_d;
  logic [W-1:0] ptr_d;
  logic         grant_mode_q, grant_mode_d;

  logic         pick_found;
  logic [W-1:0] pick_idx;
  logic [N-1:0] pick_onehot;

  prio_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .mode   (mode),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      rr_ptr       <= '0;
      grant_mode_q <= MODE_FIXED;
    end else begin
      state_q      <= state_d;
      grant_valid  <= valid_d;
      grant_idx    <= idx_d;
      grant_onehot <= onehot_d;
      rr_ptr       <= ptr_d;
      grant_mode_q <= grant_mode_d;
    end
  end

  // Mode is latched with the grant so mid-HOLD mode changes cannot affect
  // the pointer update on release.
  always_comb begin
    state_d      = state_q;
    valid_d      = grant_valid;
    idx_d        = grant_idx;
    onehot_d     = grant_onehot;
    ptr_d        = rr_ptr;
    grant_mode_d = grant_mode_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en && pick_found) begin
          state_d      = ST_HOLD;
          valid_d      = 1'b1;
          idx_d        = pick_idx;
          onehot_d     = pick_onehot;
          grant_mode_d = mode;
        end
      end
      ST_HOLD: begin
        if (ack) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b0;
          onehot_d = '0;
          if (grant_mode_q == MODE_RR)
            ptr_d = (grant_idx == W'(N - 1)) ? '0 : grant_idx + W'(1);
        end else if (!req[grant_idx]) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b0;
          onehot_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_prio_encoder.sv
// Directed vector bench for rr_prio_encoder (N=4 table plus N=5 wrap sequence).
module tb_rr_prio_encoder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       en4, mode4, ack4;
  logic [3:0] req4;
  logic       v4;
  logic [1:0] idx4, ptr4;
  logic [3:0] oh4;

  logic       en5, mode5, ack5;
  logic [4:0] req5;
  logic       v5;
  logic [2:0] idx5, ptr5;
  logic [4:0] oh5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_prio_encoder #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .req(req4), .ack(ack4),
    .grant_valid(v4), .grant_idx(idx4), .grant_onehot(oh4), .rr_ptr(ptr4)
  );

  rr_prio_encoder #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .mode(mode5), .req(req5), .ack(ack5),
    .grant_valid(v5), .grant_idx(idx5), .grant_onehot(oh5), .rr_ptr(ptr5)
  );

  typedef struct {
    logic       en;
    logic       mode;
    logic [3:0] req;
    logic       ack;
    logic       v;
    logic [1:0] idx;
    logic [3:0] oh;
    logic [1:0] ptr;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string name, input logic ev, input logic [1:0] eidx,
                        input logic [3:0] eoh, input logic [1:0] eptr);
    n_tests++;
    if ({v4, idx4, oh4, ptr4} !== {ev, eidx, eoh, eptr}) begin
      n_fail++;
      $display("FAIL %s: got v=%b idx=%0d oh=%b ptr=%0d, want v=%b idx=%0d oh=%b ptr=%0d",
               name, v4, idx4, oh4, ptr4, ev, eidx, eoh, eptr);
    end
  endtask

  task automatic check5(input string name, input logic ev, input logic [2:0] eidx,
                        input logic [4:0] eoh, input logic [2:0] eptr);
    n_tests++;
    if ({v5, idx5, oh5, ptr5} !== {ev, eidx, eoh, eptr}) begin
      n_fail++;
      $display("FAIL %s: got v=%b idx=%0d oh=%b ptr=%0d, want v=%b idx=%0d oh=%b ptr=%0d",
               name, v5, idx5, oh5, ptr5, ev, eidx, eoh, eptr);
    end
  endtask

  initial begin
    // en mode req ack | v idx oh ptr
    tbl.push_back('{1'b1, 1'b0, 4'b0110, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd0}); // fixed grant
    tbl.push_back('{1'b1, 1'b0, 4'b0110, 1'b1, 1'b0, 2'd2, 4'b0000, 2'd0}); // ack, ptr kept
    tbl.push_back('{1'b1, 1'b0, 4'b0110, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd0});
    tbl.push_back('{1'b1, 1'b0, 4'b0110, 1'b1, 1'b0, 2'd2, 4'b0000, 2'd0});
    tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001, 2'd0}); // rr 0
    tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd1});
    tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 2'd1}); // ack in idle ignored
    tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd1, 4'b0000, 2'd2});
    tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100, 2'd2});
    tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd2, 4'b0000, 2'd3});
    tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd3});
    tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd0}); // ptr wraps
    tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0});
    tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd1});
    tbl.push_back('{1'b1, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 2'd1}); // search wraps
    tbl.push_back('{1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd1});
    tbl.push_back('{1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd1}); // en=0, idx held
    tbl.push_back('{1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd1});
    tbl.push_back('{1'b1, 1'b0, 4'b0011, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd1}); // fixed ignores ptr
    tbl.push_back('{1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, 2'd1, 4'b0000, 2'd1});
    tbl.push_back('{1'b1, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd1});
    tbl.push_back('{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000, 2'd1}); // withdrawal
    tbl.push_back('{1'b1, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd1});
    tbl.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 2'd3}); // ack + withdraw
    tbl.push_back('{1'b1, 1'b0, 4'b0101, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd3});
    tbl.push_back('{1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd3}); // hold stable
    tbl.push_back('{1'b1, 1'b1, 4'b0110, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd3});
    tbl.push_back('{1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd3});

    rst_n = 1'b0;
    en4 = 1'b1; mode4 = 1'b0; req4 = 4'b1111; ack4 = 1'b0;
    en5 = 1'b0; mode5 = 1'b0; req5 = '0;      ack5 = 1'b0;

    tick(); tick();
    check4("reset_held", 1'b0, 2'd0, 4'b0000, 2'd0);
    check5("reset_held_n5", 1'b0, 3'd0, 5'b00000, 3'd0);

    rst_n = 1'b1;
    tick();
    check4("first_grant", 1'b1, 2'd3, 4'b1000, 2'd0);
    ack4 = 1'b1;
    tick();
    check4("first_release", 1'b0, 2'd3, 4'b0000, 2'd0);

    foreach (tbl[i]) begin
      en4 = tbl[i].en; mode4 = tbl[i].mode; req4 = tbl[i].req; ack4 = tbl[i].ack;
      tick();
      check4($sformatf("row%0d", i), tbl[i].v, tbl[i].idx, tbl[i].oh, tbl[i].ptr);
    end

    // N=5: drive pointer to 4, then wrap search and pointer wrap.
    en5 = 1'b1; mode5 = 1'b1; req5 = 5'b01000; ack5 = 1'b0;
    tick(); check5("n5_grant3", 1'b1, 3'd3, 5'b01000, 3'd0);
    ack5 = 1'b1;
    tick(); check5("n5_ack3", 1'b0, 3'd3, 5'b00000, 3'd4);
    req5 = 5'b00011; ack5 = 1'b0;
    tick(); check5("n5_wrap_grant", 1'b1, 3'd0, 5'b00001, 3'd4);
    ack5 = 1'b1;
    tick(); check5("n5_wrap_ack", 1'b0, 3'd0, 5'b00000, 3'd1);
    req5 = 5'b10000; ack5 = 1'b0;
    tick(); check5("n5_grant4", 1'b1, 3'd4, 5'b10000, 3'd1);
    ack5 = 1'b1;
    tick(); check5("n5_ptr_wrap", 1'b0, 3'd4, 5'b00000, 3'd0);

    check4("hold_persist", 1'b1, 2'd2, 4'b0100, 2'd3);

    // Asynchronous reset mid-HOLD, checked well before the next edge.
    rst_n = 1'b0;
    #1;
    check4("async_reset", 1'b0, 2'd0, 4'b0000, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
